// File: rtl/omsp_gfx_lcd_refresh_if_if.sv
// Signal bundle of the LCD refresh interface: backend pixel handshake plus the
// 8080-style LCD write bus. "master" is the refresh block, "slave" the far side.
interface omsp_gfx_lcd_refresh_if_if;
  logic [15:0] refresh_data_i;
  logic        refresh_data_ready_i;
  logic        refresh_active_o;
  logic        refresh_data_request_o;
  logic        lcd_cs_n_o;
  logic        lcd_rs_o;
  logic        lcd_wr_n_o;
  logic [15:0] lcd_d_o;
  logic        lcd_d_en_o;

  modport master (
    input  refresh_data_i,
    input  refresh_data_ready_i,
    output refresh_active_o,
    output refresh_data_request_o,
    output lcd_cs_n_o,
    output lcd_rs_o,
    output lcd_wr_n_o,
    output lcd_d_o,
    output lcd_d_en_o
  );

  modport slave (
    output refresh_data_i,
    output refresh_data_ready_i,
    input  refresh_active_o,
    input  refresh_data_request_o,
    input  lcd_cs_n_o,
    input  lcd_rs_o,
    input  lcd_wr_n_o,
    input  lcd_d_o,
    input  lcd_d_en_o
  );
endinterface

// File: rtl/omsp_gfx_lcd_refresh_if.sv
// LCD frame refresh: pulls pixels from the backend and writes them on an 8080 bus.
// Define OMSP_GFX_LCD_CMD_PREFIX_EN to start each frame with a 0x002C command write.
`ifndef SPIX_MSB
`define SPIX_MSB 15
`endif

module omsp_gfx_lcd_refresh_if (
  input  logic                       mclk,
  input  logic                       puc_rst_n,
  input  logic                       refresh_start_i,
  input  logic [`SPIX_MSB:0]         display_size_i,
  input  logic [3:0]                 lcd_wr_cycle_i,
  output logic                       refresh_done_o,
  omsp_gfx_lcd_refresh_if_if.master  bus
);

  localparam int            PW      = `SPIX_MSB + 1;
  localparam logic [PW-1:0] PIX_ONE = PW'(1);
`ifdef OMSP_GFX_LCD_CMD_PREFIX_EN
  localparam logic [15:0]   LCD_CMD_MEM_WRITE = 16'h002C;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_LO, S_CMD_HI, S_REQ, S_WAIT, S_WR_LO, S_WR_HI, S_DONE
  } state_e;

  state_e        state_q,     state_d;
  logic [PW-1:0] pix_cnt_q,   pix_cnt_d;
  logic [3:0]    wr_cycle_q,  wr_cycle_d;
  logic [3:0]    phase_cnt_q, phase_cnt_d;
  logic [15:0]   lcd_d_q,     lcd_d_d;
  logic          lcd_rs_q,    lcd_rs_d;
  logic          active_q,    active_d;
  logic          request_q,   request_d;
  logic          done_q,      done_d;
  logic          wr_n_q,      wr_n_d;
  logic          cs_n_q;
  logic          d_en_q;
  logic          phase_last;

  assign phase_last = (phase_cnt_q == wr_cycle_q);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    wr_cycle_d  = wr_cycle_q;
    phase_cnt_d = phase_cnt_q;
    lcd_d_d     = lcd_d_q;
    lcd_rs_d    = lcd_rs_q;

    unique case (state_q)
      S_IDLE: begin
        if (refresh_start_i) begin
          pix_cnt_d   = display_size_i;
          wr_cycle_d  = lcd_wr_cycle_i;
          phase_cnt_d = '0;
`ifdef OMSP_GFX_LCD_CMD_PREFIX_EN
          state_d     = S_CMD_LO;
          lcd_d_d     = LCD_CMD_MEM_WRITE;
          lcd_rs_d    = 1'b0;
`else
          state_d     = (display_size_i == '0) ? S_DONE : S_REQ;
`endif
        end
      end
`ifdef OMSP_GFX_LCD_CMD_PREFIX_EN
      S_CMD_LO: begin
        phase_cnt_d = phase_last ? '0 : phase_cnt_q + 4'd1;
        if (phase_last) state_d = S_CMD_HI;
      end
      S_CMD_HI: begin
        phase_cnt_d = phase_last ? '0 : phase_cnt_q + 4'd1;
        if (phase_last) state_d = (pix_cnt_q == '0) ? S_DONE : S_REQ;
      end
`endif
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.refresh_data_ready_i) begin
          lcd_d_d     = bus.refresh_data_i;
          lcd_rs_d    = 1'b1;
          phase_cnt_d = '0;
          state_d     = S_WR_LO;
        end
      end
      S_WR_LO: begin
        phase_cnt_d = phase_last ? '0 : phase_cnt_q + 4'd1;
        if (phase_last) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        phase_cnt_d = phase_last ? '0 : phase_cnt_q + 4'd1;
        if (phase_last) begin
          pix_cnt_d = pix_cnt_q - PIX_ONE;
          state_d   = (pix_cnt_q == PIX_ONE) ? S_DONE : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop aligned with state_q.
  always_comb begin
    active_d  = !(state_d inside {S_IDLE, S_DONE});
    request_d = (state_d == S_REQ);
    done_d    = (state_d == S_DONE);
    wr_n_d    = !(state_d inside {S_CMD_LO, S_WR_LO});
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      wr_cycle_q  <= '0;
      phase_cnt_q <= '0;
      lcd_d_q     <= 16'h0000;
      lcd_rs_q    <= 1'b1;
      active_q    <= 1'b0;
      request_q   <= 1'b0;
      done_q      <= 1'b0;
      wr_n_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      d_en_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      wr_cycle_q  <= wr_cycle_d;
      phase_cnt_q <= phase_cnt_d;
      lcd_d_q     <= lcd_d_d;
      lcd_rs_q    <= lcd_rs_d;
      active_q    <= active_d;
      request_q   <= request_d;
      done_q      <= done_d;
      wr_n_q      <= wr_n_d;
      cs_n_q      <= ~active_d;
      d_en_q      <= active_d;
    end
  end

  assign refresh_done_o             = done_q;
  assign bus.refresh_active_o       = active_q;
  assign bus.refresh_data_request_o = request_q;
  assign bus.lcd_cs_n_o             = cs_n_q;
  assign bus.lcd_rs_o               = lcd_rs_q;
  assign bus.lcd_wr_n_o             = wr_n_q;
  assign bus.lcd_d_o                = lcd_d_q;
  assign bus.lcd_d_en_o             = d_en_q;

endmodule

// File: tb/tb_omsp_gfx_lcd_refresh_if.sv
// Scoreboard bench for omsp_gfx_lcd_refresh_if: stimulus queues expected LCD writes
// and end-of-frame timing; a negedge monitor compares them as the DUT produces them.
`ifndef SPIX_MSB
`define SPIX_MSB 15
`endif

module tb_omsp_gfx_lcd_refresh_if;

  localparam int PW = `SPIX_MSB + 1;
`ifdef OMSP_GFX_LCD_CMD_PREFIX_EN
  localparam bit PREFIX = 1'b1;
`else
  localparam bit PREFIX = 1'b0;
`endif

  typedef struct { logic rs; logic [15:0] data; int n; } wr_t;
  typedef struct { longint cyc; int reqs; } done_t;

  logic          mclk          = 1'b0;
  logic          puc_rst_n     = 1'b0;
  logic          refresh_start = 1'b0;
  logic [PW-1:0] display_size  = '0;
  logic [3:0]    lcd_wr_cycle  = 4'd0;
  logic          refresh_done;
  logic [15:0]   be_data       = 16'h0000;
  logic          be_ready      = 1'b0;
  logic          sp_ready      = 1'b0;
  int            be_lat        = 1;
  longint        cyc           = 0;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int bad_chg = 0;
  int lo_len  = 0;

  wr_t         exp_wr_q[$];
  done_t       exp_done_q[$];
  logic [15:0] be_q[$];

  omsp_gfx_lcd_refresh_if_if bus();

  assign bus.refresh_data_i       = sp_ready ? 16'hDEAD : be_data;
  assign bus.refresh_data_ready_i = be_ready | sp_ready;

  omsp_gfx_lcd_refresh_if dut (
    .mclk            (mclk),
    .puc_rst_n       (puc_rst_n),
    .refresh_start_i (refresh_start),
    .display_size_i  (display_size),
    .lcd_wr_cycle_i  (lcd_wr_cycle),
    .refresh_done_o  (refresh_done),
    .bus             (bus)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"},  32'(bus.refresh_active_o),       32'd0);
    check({tag, "_request"}, 32'(bus.refresh_data_request_o), 32'd0);
    check({tag, "_done"},    32'(refresh_done),               32'd0);
    check({tag, "_cs_n"},    32'(bus.lcd_cs_n_o),             32'd1);
    check({tag, "_rs"},      32'(bus.lcd_rs_o),               32'd1);
    check({tag, "_wr_n"},    32'(bus.lcd_wr_n_o),             32'd1);
    check({tag, "_d"},       32'(bus.lcd_d_o),                32'h0000);
    check({tag, "_d_en"},    32'(bus.lcd_d_en_o),             32'd0);
  endtask

  // Backend model: answers each request after be_lat cycles with the next queued pixel.
  initial begin : backend
    logic [15:0] px;
    forever begin
      @(negedge mclk);
      if (puc_rst_n && bus.refresh_data_request_o) begin
        px = (be_q.size() > 0) ? be_q.pop_front() : 16'hBAD0;
        repeat (be_lat) @(posedge mclk);
        #1;
        be_data  = px;
        be_ready = 1'b1;
        @(posedge mclk);
        #1 be_ready = 1'b0;
      end
    end
  end

  // Monitor: a write completes on each WR_N rising edge; data/RS may only change
  // together with a WR_N falling edge.
  initial begin : monitor
    logic        prev_wr_n;
    logic        prev_rs;
    logic [15:0] prev_d;
    prev_wr_n = 1'b1;
    prev_rs   = 1'b1;
    prev_d    = 16'h0000;
    forever begin
      @(negedge mclk);
      if (!puc_rst_n) begin
        req_cnt = 0;
        bad_chg = 0;
        lo_len  = 0;
      end else begin
        if ((bus.lcd_d_o !== prev_d || bus.lcd_rs_o !== prev_rs) &&
            !(prev_wr_n && !bus.lcd_wr_n_o))
          bad_chg++;
        if (!bus.lcd_wr_n_o) lo_len = prev_wr_n ? 1 : lo_len + 1;
        if (!prev_wr_n && bus.lcd_wr_n_o) begin
          if (exp_wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: rs=%0d data=0x%04h with none expected", bus.lcd_rs_o, bus.lcd_d_o);
          end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            check("wr_rs",     32'(bus.lcd_rs_o), 32'(e.rs));
            check("wr_data",   32'(bus.lcd_d_o),  32'(e.data));
            check("wr_lo_len", 32'(lo_len),       32'(e.n + 1));
            check("wr_stable", 32'(bad_chg),      32'd0);
          end
          bad_chg = 0;
        end
        if (bus.refresh_data_request_o) req_cnt++;
        if (refresh_done) begin
          if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done pulse at cycle %0d with none expected", cyc);
          end else begin
            done_t d;
            d = exp_done_q.pop_front();
            check("done_cycle",   32'(cyc),     32'(d.cyc));
            check("req_count",    32'(req_cnt), 32'(d.reqs));
            check("frame_stable", 32'(bad_chg), 32'd0);
          end
          req_cnt = 0;
          bad_chg = 0;
        end
      end
      prev_wr_n = bus.lcd_wr_n_o;
      prev_rs   = bus.lcd_rs_o;
      prev_d    = bus.lcd_d_o;
    end
  end

  // Pulses start in the next cycle T and queues the frame's expected writes and end time.
  task automatic start_frame(input int s, input int n, input int lat,
                             input logic [15:0] base, input logic [15:0] step);
    logic [15:0] px;
    @(posedge mclk);
    #1;
    display_size = PW'(s);
    lcd_wr_cycle = 4'(n);
    be_lat       = lat;
    if (PREFIX) exp_wr_q.push_back('{1'b0, 16'h002C, n});
    for (int i = 0; i < s; i++) begin
      px = 16'(base + 16'(i) * step);
      be_q.push_back(px);
      exp_wr_q.push_back('{1'b1, px, n});
    end
    exp_done_q.push_back('{cyc + 1 + (PREFIX ? 2 * (n + 1) : 0) + s * (1 + lat + 2 * (n + 1)), s});
    refresh_start = 1'b1;
    @(posedge mclk);
    #1 refresh_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (exp_done_q.size() != 0 && k < budget) begin
      @(posedge mclk);
      k++;
    end
    if (exp_done_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: frame not finished within %0d cycles", name, budget);
      exp_done_q.delete();
    end
    repeat (2) @(posedge mclk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    repeat (3) @(posedge mclk);
    #1 check_reset_outputs("reset");
    puc_rst_n = 1'b1;
    repeat (2) @(posedge mclk);

    // N=0, S=4, L=1
    start_frame(4, 0, 1, 16'h1111, 16'h1111);
    wait_done("frame_basic", 200);

    // N=3, S=2, L=5: long strobes, slow backend
    start_frame(2, 3, 5, 16'hA5A5, 16'h1234);
    wait_done("frame_slow", 200);

    // Empty frame
    start_frame(0, 0, 1, 16'h0000, 16'h0000);
    for (int r = 1; r <= 4; r++) begin
      @(negedge mclk);
      check("zero_active", 32'(bus.refresh_active_o), (PREFIX && r <= 2) ? 32'd1 : 32'd0);
      check("zero_wr_n",   32'(bus.lcd_wr_n_o),       (PREFIX && r == 1) ? 32'd0 : 32'd1);
    end
    wait_done("frame_zero", 50);

    // Restart and spurious ready during a WR_HI phase are ignored
    start_frame(3, 1, 2, 16'h1357, 16'h2222);
    k = 0;
    while (bus.lcd_wr_n_o !== 1'b0 && k < 100) begin @(negedge mclk); k++; end
    while (bus.lcd_wr_n_o !== 1'b1 && k < 100) begin @(negedge mclk); k++; end
    check("spurious_reached_wr_hi", 32'(bus.lcd_wr_n_o), 32'd1);
    @(posedge mclk);
    #1;
    refresh_start = 1'b1;
    sp_ready      = 1'b1;
    @(posedge mclk);
    #1;
    refresh_start = 1'b0;
    sp_ready      = 1'b0;
    wait_done("frame_spurious", 200);

    // Reset while waiting for pixel 3 of 10, then a full frame
    start_frame(10, 0, 4, 16'h0100, 16'h0101);
    k = 0;
    while (req_cnt < 3 && k < 200) begin @(posedge mclk); k++; end
    check("rst_reached_pixel3", 32'(req_cnt), 32'd3);
    #3 puc_rst_n = 1'b0;
    #1 check_reset_outputs("midframe_rst");
    exp_wr_q.delete();
    exp_done_q.delete();
    be_q.delete();
    repeat (3) @(posedge mclk);
    #1 puc_rst_n = 1'b1;
    repeat (8) @(posedge mclk);
    start_frame(10, 0, 4, 16'h0200, 16'h0101);
    wait_done("frame_after_rst", 300);

    // Strobe length change mid-frame only affects the next frame
    start_frame(2, 0, 1, 16'h0F0F, 16'h1010);
    lcd_wr_cycle = 4'd7;
    display_size = PW'(5);
    wait_done("frame_cfg_old", 100);
    start_frame(1, 7, 1, 16'hCAFE, 16'h0000);
    wait_done("frame_cfg_new", 100);

    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("be_q_drained", 32'(be_q.size()),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
